// File: rtl/matmul_seq.sv
// matmul_seq: multi-cycle sequencer for the 2x2 matrix-multiply instruction.
// While the MEM stage holds a matrix-mult op, this block owns the data-memory
// port and stalls the pipeline. It loads A and B (eight reads), computes
// C = A x B one element per cycle with DATA_W-bit wrap, writes C back
// (four writes), then pulses done for one cycle and hands the port back.
// All loads happen before any store, so C may overlap A or B.
module matmul_seq #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] a_base,
   input  logic [ADDR_W-1:0] b_base,
   input  logic [ADDR_W-1:0] c_base,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              stall,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CALC  = 3'd2,
      S_STORE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] aBase_q, aBase_d;
   logic [ADDR_W-1:0] bBase_q, bBase_d;
   logic [ADDR_W-1:0] cBase_q, cBase_d;

   // Operands: index 0..3 = a00,a01,a10,a11 ; 4..7 = b00,b01,b10,b11
   logic [DATA_W-1:0] opnd_q [0:7];
   logic [DATA_W-1:0] opnd_d [0:7];
   // Results: c00,c01,c10,c11
   logic [DATA_W-1:0] res_q [0:3];
   logic [DATA_W-1:0] res_d [0:3];

   logic [1:0]        jIdx;
   logic [DATA_W-1:0] aRow0, aRow1, bCol0, bCol1;
   logic [DATA_W-1:0] prod0, prod1, elemSum;

   // Dot product for result element j = 2i+c, truncated to DATA_W bits.
   always_comb begin
      jIdx    = cnt_q[1:0];
      aRow0   = opnd_q[{1'b0, jIdx[1], 1'b0}];
      aRow1   = opnd_q[{1'b0, jIdx[1], 1'b1}];
      bCol0   = opnd_q[{2'b10, jIdx[0]}];
      bCol1   = opnd_q[{2'b11, jIdx[0]}];
      prod0   = aRow0 * bCol0;
      prod1   = aRow1 * bCol1;
      elemSum = prod0 + prod1;
   end

   // Next-state logic: sequencing counter, operand capture and result update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      aBase_d = aBase_q;
      bBase_d = bBase_q;
      cBase_d = cBase_q;
      opnd_d  = opnd_q;
      res_d   = res_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               aBase_d = a_base;
               bBase_d = b_base;
               cBase_d = c_base;
               cnt_d   = 3'd0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            opnd_d[cnt_q] = mem_rdata;
            if (cnt_q == 3'd7) begin
               cnt_d   = 3'd0;
               state_d = S_CALC;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_CALC: begin
            res_d[jIdx] = elemSum;
            if (cnt_q == 3'd3) begin
               cnt_d   = 3'd0;
               state_d = S_STORE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_STORE: begin
            if (cnt_q == 3'd3) begin
               cnt_d   = 3'd0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_DONE: begin
            // A still-high start must not retrigger here.
            cnt_d   = 3'd0;
            state_d = S_IDLE;
         end
         default: begin
            cnt_d   = 3'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State, counter, latched bases and data registers; async active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         aBase_q <= '0;
         bBase_q <= '0;
         cBase_q <= '0;
         opnd_q  <= '{default: '0};
         res_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         aBase_q <= aBase_d;
         bBase_q <= bBase_d;
         cBase_q <= cBase_d;
         opnd_q  <= opnd_d;
         res_q   <= res_d;
      end
   end

   // Memory-port decode from registered state only; address/data forced to 0
   // whenever the port is not owned. stall is the sole start-to-output path
   // and is gated by reset so every output is 0 while reset is asserted.
   always_comb begin
      mem_sel   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      stall     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            stall = start & reset;
         end
         S_LOAD: begin
            mem_sel = 1'b1;
            stall   = 1'b1;
            if (!cnt_q[2]) begin
               mem_addr = aBase_q + ADDR_W'(cnt_q[1:0]);
            end else begin
               mem_addr = bBase_q + ADDR_W'(cnt_q[1:0]);
            end
         end
         S_CALC: begin
            stall = 1'b1;
         end
         S_STORE: begin
            mem_sel   = 1'b1;
            mem_we    = 1'b1;
            stall     = 1'b1;
            mem_addr  = cBase_q + ADDR_W'(cnt_q[1:0]);
            mem_wdata = res_q[cnt_q[1:0]];
         end
         S_DONE: begin
            stall = 1'b0;
         end
         default: begin
            stall = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: directed bench for matmul_seq with a behavioural
// asynchronous-read data memory and hand-computed expected products.
module tb_matmul_seq;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] aBase, bBase, cBase;
   logic [7:0] memRdata;
   logic       memSel;
   logic [7:0] memAddr;
   logic [7:0] memWdata;
   logic       memWe;
   logic       stall, busy, done;

   logic [7:0] mem [0:255];

   int checks;
   int errors;

   // Per-run observations collected cycle by cycle
   int doneCycle, doneCount, stallCount, lastStall, weCount, firstWe, busyCount;
   logic [7:0] addrAt [0:20];

   matmul_seq #(.DATA_W(8), .ADDR_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .a_base    (aBase),
      .b_base    (bBase),
      .c_base    (cBase),
      .mem_rdata (memRdata),
      .mem_sel   (memSel),
      .mem_addr  (memAddr),
      .mem_wdata (memWdata),
      .mem_we    (memWe),
      .stall     (stall),
      .busy      (busy),
      .done      (done)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Asynchronous-read memory, write on rising edge when the sequencer owns it
   assign memRdata = mem[memAddr];

   always @(posedge clk) begin
      if (memSel && memWe) mem[memAddr] <= memWdata;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_stall"}, {31'd0, stall}, 32'd0);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
      checkOutput({tag, "_sel"}, {31'd0, memSel}, 32'd0);
      checkOutput({tag, "_we"}, {31'd0, memWe}, 32'd0);
      checkOutput({tag, "_addr"}, {24'd0, memAddr}, 32'd0);
      checkOutput({tag, "_wdata"}, {24'd0, memWdata}, 32'd0);
   endtask

   task automatic writeMat(input logic [7:0] base, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
      mem[base]        = e0;
      mem[base + 8'd1] = e1;
      mem[base + 8'd2] = e2;
      mem[base + 8'd3] = e3;
   endtask

   // Runs 21 cycles starting with start=1 at cycle 0; start stays high through
   // cycle holdLast. If resetAt >= 0, reset is asserted in that cycle.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                input int holdLast, input int resetAt);
      doneCycle = -1; doneCount = 0; stallCount = 0; lastStall = -1;
      weCount = 0; firstWe = -1; busyCount = 0;
      @(posedge clk); #1;
      aBase = a; bBase = b; cBase = c;
      for (int t = 0; t <= 20; t++) begin
         if (t > 0) begin
            @(posedge clk); #1;
            // Scramble bases after acceptance; they must have no effect
            aBase = 8'hC3; bBase = 8'h3C; cBase = 8'h99;
         end
         start = (t <= holdLast);
         if (t == resetAt) reset = 1'b0;
         #1;
         if (t == resetAt) checkAllZero("midReset");
         addrAt[t] = memAddr;
         if (stall) begin stallCount++; lastStall = t; end
         if (busy) busyCount++;
         if (done) begin doneCount++; doneCycle = t; end
         if (memWe) begin weCount++; if (firstWe < 0) firstWe = t; end
      end
      start = 1'b0;
   endtask

   initial begin
      int idleBad;
      checks = 0;
      errors = 0;
      start  = 1'b0;
      aBase  = 8'h00; bBase = 8'h00; cBase = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      // Reset: outputs all zero even if start is high
      reset = 1'b0;
      start = 1'b1;
      #12;
      checkAllZero("reset");
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      checkOutput("afterReset_busy", {31'd0, busy}, 32'd0);

      // Basic product
      writeMat(8'h10, 8'd1, 8'd2, 8'd3, 8'd4);
      writeMat(8'h20, 8'd5, 8'd6, 8'd7, 8'd8);
      writeMat(8'h30, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
      applyStimulus(8'h10, 8'h20, 8'h30, 0, -1);
      checkOutput("basic_c00", {24'd0, mem[8'h30]}, 32'd19);
      checkOutput("basic_c01", {24'd0, mem[8'h31]}, 32'd22);
      checkOutput("basic_c10", {24'd0, mem[8'h32]}, 32'd43);
      checkOutput("basic_c11", {24'd0, mem[8'h33]}, 32'd50);
      checkOutput("basic_doneCycle", doneCycle, 32'd17);
      checkOutput("basic_doneCount", doneCount, 32'd1);
      checkOutput("basic_stallCount", stallCount, 32'd17);
      checkOutput("basic_lastStall", lastStall, 32'd16);
      checkOutput("basic_weCount", weCount, 32'd4);
      checkOutput("basic_firstWe", firstWe, 32'd13);
      checkOutput("basic_busyCount", busyCount, 32'd17);
      checkOutput("basic_addrLoad0", {24'd0, addrAt[1]}, 32'h10);
      checkOutput("basic_addrLoad4", {24'd0, addrAt[5]}, 32'h20);
      checkOutput("basic_addrStore3", {24'd0, addrAt[16]}, 32'h33);
      checkOutput("basic_addrCalc", {24'd0, addrAt[10]}, 32'h00);

      // Overflow: 200*2 + 100*1 = 500 -> 244
      writeMat(8'h40, 8'd200, 8'd100, 8'd0, 8'd0);
      writeMat(8'h50, 8'd2, 8'd0, 8'd1, 8'd0);
      writeMat(8'h60, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
      applyStimulus(8'h40, 8'h50, 8'h60, 0, -1);
      checkOutput("ovf_c00", {24'd0, mem[8'h60]}, 32'd244);
      checkOutput("ovf_c01", {24'd0, mem[8'h61]}, 32'd0);
      checkOutput("ovf_c10", {24'd0, mem[8'h62]}, 32'd0);
      checkOutput("ovf_c11", {24'd0, mem[8'h63]}, 32'd0);

      // Address wrap with C overlapping A
      mem[8'hFE] = 8'd2; mem[8'hFF] = 8'd3; mem[8'h00] = 8'd4; mem[8'h01] = 8'd5;
      writeMat(8'h80, 8'd6, 8'd7, 8'd8, 8'd9);
      applyStimulus(8'hFE, 8'h80, 8'hFE, 0, -1);
      checkOutput("wrap_c00", {24'd0, mem[8'hFE]}, 32'd36);
      checkOutput("wrap_c01", {24'd0, mem[8'hFF]}, 32'd41);
      checkOutput("wrap_c10", {24'd0, mem[8'h00]}, 32'd64);
      checkOutput("wrap_c11", {24'd0, mem[8'h01]}, 32'd73);
      checkOutput("wrap_addrLoad2", {24'd0, addrAt[3]}, 32'h00);
      checkOutput("wrap_firstWe", firstWe, 32'd13);

      // Held start through DONE, dropped the cycle after
      writeMat(8'h70, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
      applyStimulus(8'h10, 8'h20, 8'h70, 17, -1);
      checkOutput("hold_busyCount", busyCount, 32'd17);
      checkOutput("hold_doneCount", doneCount, 32'd1);
      checkOutput("hold_weCount", weCount, 32'd4);
      checkOutput("hold_c11", {24'd0, mem[8'h73]}, 32'd50);
      // Fresh run after re-assertion
      applyStimulus(8'h40, 8'h50, 8'h74, 0, -1);
      checkOutput("rerun_doneCycle", doneCycle, 32'd17);
      checkOutput("rerun_busyCount", busyCount, 32'd17);
      checkOutput("rerun_c00", {24'd0, mem[8'h74]}, 32'd244);

      // Reset during STORE j=1 (cycle 14)
      writeMat(8'h90, 8'h55, 8'h55, 8'h55, 8'h55);
      applyStimulus(8'h10, 8'h20, 8'h90, 0, 14);
      checkOutput("midReset_c00Written", {24'd0, mem[8'h90]}, 32'd19);
      checkOutput("midReset_c01Untouched", {24'd0, mem[8'h91]}, 32'h55);
      checkOutput("midReset_doneCount", doneCount, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      for (int t = 0; t < 5; t++) begin
         @(posedge clk); #1;
      end
      checkOutput("postReset_busy", {31'd0, busy}, 32'd0);
      checkOutput("postReset_sel", {31'd0, memSel}, 32'd0);

      // Idle quiet for 50 cycles
      idleBad = 0;
      start = 1'b0;
      for (int t = 0; t < 50; t++) begin
         @(posedge clk); #1;
         if (stall || busy || done || memSel || memWe || (memAddr != 8'h00) || (memWdata != 8'h00))
            idleBad++;
      end
      checkOutput("idle_activity", idleBad, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/matmul_seq.md
Name: matmul_seq

Overview:
Multi-cycle sequencer for the 2x2 matrix-multiply instruction. When the MEM stage holds a matrix-mult op, it takes ownership of the data-memory port and stalls the pipeline. It then loads operand matrices A and B, computes C = A x B with 8-bit wrap, stores C, and releases the port. It sits beside the EX/MEM pipeline register: the MEM-stage flag and addresses feed this block, and a mux on mem_sel hands the data-memory port to it.

Parameters:
DATA_W, 8, element and memory data width
ADDR_W, 8, data-memory address width

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
start  in  1  MEM-stage matrix-mult flag (is_matrix_mult_m)
a_base  in  ADDR_W  base address of A, row-major a00,a01,a10,a11
b_base  in  ADDR_W  base address of B, row-major
c_base  in  ADDR_W  base address of C, row-major
mem_rdata  in  DATA_W  data-memory read data, combinational (asynchronous read)
mem_sel  out  1  1 = sequencer drives data-memory port
mem_addr  out  ADDR_W  data-memory address
mem_wdata  out  DATA_W  data-memory write data
mem_we  out  1  data-memory write enable
stall  out  1  freeze PC/IF_ID/ID_EX/EX_MEM, bubble into MEM_WB
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, any state, async): state=IDLE, counter=0, operand and result registers=0. All outputs 0, including mid-operation. No partial write completes after reset is asserted.
- States: IDLE -> LOAD (8 cycles) -> CALC (4) -> STORE (4) -> DONE (1) -> IDLE.
- IDLE: start=1 latches a_base/b_base/c_base and moves to LOAD at the next edge. stall = start (combinational, same cycle). All other outputs 0.
- LOAD, idx k=0..7: mem_sel=1, mem_we=0. mem_addr = a_base+k for k<4, b_base+(k-4) for k>=4, modulo 2^ADDR_W. mem_rdata captured into operand k at the clock edge ending the cycle.
- CALC, idx j=0..3 (j=2i+c): C[j] = A[i][0]*B[0][c] + A[i][1]*B[1][c]. Products and sum are truncated to DATA_W bits (mod 256). One element is registered per cycle. mem_sel=0.
- STORE, idx j=0..3: mem_sel=1, mem_we=1, mem_addr = c_base+j (wrap), mem_wdata = C[j].
- DONE: done=1, stall=0, mem_sel=0. The pipeline advances this cycle. Always returns to IDLE. start is ignored in DONE, so a still-high flag cannot retrigger.
- stall = 1 in LOAD/CALC/STORE, and in IDLE when start=1. Otherwise 0.
- Total: start accepted at cycle 0 (stall high), LOAD cycles 1-8, CALC 9-12, STORE 13-16, done at 17.
- Base addresses are latched. Input changes after acceptance have no effect.
- All loads precede all stores, so c_base overlapping A or B still gives the correct product.
- mem_* outputs decode only from registered state/counter/data. The only combinational input-to-output path is start->stall.
- mem_addr/mem_wdata = 0 whenever mem_sel=0.

Test Plan:
- Basic: A=[[1,2],[3,4]] at 0x10, B=[[5,6],[7,8]] at 0x20, c_base=0x30, pulse start. Required: mem 0x30..0x33 = 19,22,43,50. done at cycle 17. stall high cycles 0-16. mem_we high exactly 4 cycles.
- Overflow: A=[[200,100],[0,0]], B=[[2,0],[1,0]]. Required: C[0] = 500 mod 256 = 244; remaining elements 0.
- Wrap and overlap: a_base=0xFE, so reads hit 0xFE,0xFF,0x00,0x01. c_base=a_base. Required: correct product written over A. No store occurs before cycle 13.
- Held start: keep start=1 through DONE and drop it one cycle after. Required: a single operation, IDLE afterwards, no second LOAD. Re-asserting start later triggers a fresh 17-cycle run.
- Reset mid-op: drive reset=0 during STORE j=1. Required: all outputs 0 immediately (async), state IDLE. After release, idle until the next start.
- Idle quiet: start=0 for 50 cycles. Required: stall, busy, done, mem_sel, mem_we all 0, and no memory address activity.
